// File: rtl/puf_response_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : puf_response_ctrl
// Purpose  : Clock-domain sequencer that builds a RESP_BITS-bit PUF response
//            from one challenge. For each response bit it selects an
//            oscillator pair, enables the banks, counts synchronized rising
//            edges of both selected oscillators over WINDOW clk cycles and
//            stores (cnt_a > cnt_b).
// Ports    : clk, rst_n (async, active-high), start, challenge {B,A} bases,
//            ro_a/ro_b (async oscillator outputs), ro_ena, sel_a, sel_b,
//            busy, done (1-cycle pulse), response, tie_cnt (saturating).
// Options  : `define PUF_MAJORITY_VOTE_EN -> three measurements per bit,
//            response bit is the majority of the three results.
// Revision : 1.0 - initial release
// ============================================================================
module puf_response_ctrl #(
    parameter int CNT_W     = 16,
    parameter int WINDOW    = 1024,
    parameter int RESP_BITS = 8,
    parameter int SEL_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic                 ro_ena,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [7:0]           tie_cnt
);

    // Phase timer is sized from WINDOW, independent of the edge counters.
    localparam int             c_TMR_W      = (WINDOW > 4) ? $clog2(WINDOW) : 2;
    localparam int             c_K_W        = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [c_TMR_W-1:0] c_SETTLE_LAST = c_TMR_W'(3);
    localparam logic [c_TMR_W-1:0] c_WIN_LAST    = c_TMR_W'(WINDOW - 1);
    localparam logic [c_K_W-1:0]   c_K_LAST      = c_K_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_COUNT   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_K_W-1:0]   r_k;
    logic [SEL_W-1:0]   r_base_a;
    logic [SEL_W-1:0]   r_base_b;
    logic [CNT_W-1:0]   r_cnt_a;
    logic [CNT_W-1:0]   r_cnt_b;
    logic [1:0]         r_sync_a;
    logic [1:0]         r_sync_b;
    logic               r_prev_a;
    logic               r_prev_b;

    // Two-flop synchronizers plus one history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sync_a <= 2'b00;
            r_sync_b <= 2'b00;
            r_prev_a <= 1'b0;
            r_prev_b <= 1'b0;
        end else begin
            r_sync_a <= {r_sync_a[0], ro_a};
            r_sync_b <= {r_sync_b[0], ro_b};
            r_prev_a <= r_sync_a[1];
            r_prev_b <= r_sync_b[1];
        end
    end

    logic                 w_rise_a;
    logic                 w_rise_b;
    logic                 w_gt;
    logic                 w_tie;
    logic                 w_bit;
    logic                 w_last_trial;
    logic [c_K_W-1:0]     w_k_inc;
    logic [RESP_BITS-1:0] w_resp_base;
    logic [7:0]           w_tie_next;

    assign w_rise_a    = r_sync_a[1] & ~r_prev_a;
    assign w_rise_b    = r_sync_b[1] & ~r_prev_b;
    assign w_gt        = (r_cnt_a > r_cnt_b);
    assign w_tie       = (r_cnt_a == r_cnt_b);
    assign w_k_inc     = r_k + c_K_W'(1);
    // Bit 0 of a run discards the previous response; later bits accumulate.
    assign w_resp_base = (r_k == '0) ? '0 : response;
    assign w_tie_next  = (w_tie && (tie_cnt != 8'hFF)) ? tie_cnt + 8'd1 : tie_cnt;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] r_trial;
    logic [1:0] r_votes;
    assign w_last_trial = (r_trial == 2'd2);
    // Majority of the two stored trials and the current one.
    assign w_bit = (r_votes[0] & r_votes[1]) | (w_gt & (r_votes[0] | r_votes[1]));
`else
    assign w_last_trial = 1'b1;
    assign w_bit        = w_gt;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state  <= S_IDLE;
            r_tmr    <= '0;
            r_k      <= '0;
            r_base_a <= '0;
            r_base_b <= '0;
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            ro_ena   <= 1'b0;
            sel_a    <= '0;
            sel_b    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
            tie_cnt  <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            r_trial  <= 2'd0;
            r_votes  <= 2'b00;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base_a <= challenge[SEL_W-1:0];
                        r_base_b <= challenge[2*SEL_W-1:SEL_W];
                        sel_a    <= challenge[SEL_W-1:0];
                        sel_b    <= challenge[2*SEL_W-1:SEL_W];
                        r_k      <= '0;
                        r_tmr    <= '0;
                        r_cnt_a  <= '0;
                        r_cnt_b  <= '0;
                        tie_cnt  <= '0;
                        busy     <= 1'b1;
                        ro_ena   <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
                        r_trial  <= 2'd0;
`endif
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Edges are ignored here so the synchronizers flush any
                    // activity from the previously selected oscillators.
                    if (r_tmr == c_SETTLE_LAST) begin
                        r_tmr   <= '0;
                        r_state <= S_COUNT;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end
                S_COUNT: begin
                    if (w_rise_a && (r_cnt_a != c_CNT_MAX)) r_cnt_a <= r_cnt_a + CNT_W'(1);
                    if (w_rise_b && (r_cnt_b != c_CNT_MAX)) r_cnt_b <= r_cnt_b + CNT_W'(1);
                    if (r_tmr == c_WIN_LAST) begin
                        r_tmr   <= '0;
                        ro_ena  <= 1'b0;
                        r_state <= S_COMPARE;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end
                S_COMPARE: begin
                    tie_cnt <= w_tie_next;
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                    if (!w_last_trial) begin
`ifdef PUF_MAJORITY_VOTE_EN
                        r_votes[r_trial[0]] <= w_gt;
                        r_trial <= r_trial + 2'd1;
`endif
                        ro_ena  <= 1'b1;
                        r_state <= S_SETTLE;
                    end else begin
                        response <= w_resp_base | (RESP_BITS'(w_bit) << r_k);
`ifdef PUF_MAJORITY_VOTE_EN
                        r_trial <= 2'd0;
`endif
                        if (r_k == c_K_LAST) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_k     <= w_k_inc;
                            sel_a   <= r_base_a + SEL_W'(w_k_inc);
                            sel_b   <= r_base_b + SEL_W'(w_k_inc);
                            ro_ena  <= 1'b1;
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_puf_response_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_response_ctrl
// Purpose  : Self-checking bench for puf_response_ctrl. Oscillator waveforms
//            are generated per clk cycle; the expected response is derived
//            from the cycle timeline of the measurement schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_puf_response_ctrl;

    localparam int CNT_W     = 4;
    localparam int WINDOW    = 64;
    localparam int RESP_BITS = 4;
    localparam int SEL_W     = 5;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int TRIALS = 3;
`else
    localparam int TRIALS = 1;
`endif
    localparam int L       = WINDOW + 5;
    localparam int NMEAS   = RESP_BITS * TRIALS;
    localparam int D       = NMEAS * L + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic [2*SEL_W-1:0]   challenge = '0;
    logic                 ro_a = 1'b0;
    logic                 ro_b = 1'b0;
    logic                 ro_ena;
    logic [SEL_W-1:0]     sel_a;
    logic [SEL_W-1:0]     sel_b;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic [7:0]           tie_cnt;

    puf_response_ctrl #(
        .CNT_W(CNT_W), .WINDOW(WINDOW), .RESP_BITS(RESP_BITS), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .ro_ena(ro_ena), .sel_a(sel_a), .sel_b(sel_b),
        .busy(busy), .done(done), .response(response), .tie_cnt(tie_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Oscillator description per measurement slot (period 0 = held low).
    int per_a [NMEAS];
    int ph_a  [NMEAS];
    int per_b [NMEAS];
    int ph_b  [NMEAS];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Level driven during cycle m of a run (m=0 is the start-sample cycle).
    function automatic bit ro_val(input int m, input bit is_a);
        int j, p, ph;
        j = (m < 1) ? 0 : (m - 1) / L;
        if (j > NMEAS - 1) j = NMEAS - 1;
        p  = is_a ? per_a[j] : per_b[j];
        ph = is_a ? ph_a[j] : per_b[j] == 0 ? 0 : ph_b[j];
        if (p == 0) return 1'b0;
        return ((m + ph) % p) < (p / 2);
    endfunction

    // A level driven in cycle m reaches the second sync flop in cycle m+2,
    // so a rise seen in count cycle c is f(c-2)=1 after f(c-3)=0.
    function automatic int edges(input int j, input bit is_a);
        int cnt = 0;
        for (int c = j * L + 5; c <= j * L + 4 + WINDOW; c++)
            if (ro_val(c - 2, is_a) && !ro_val(c - 3, is_a) && cnt < CNT_MAX) cnt++;
        return cnt;
    endfunction

    task automatic set_ro(input int pa, input int pha, input int pb, input int phb);
        for (int j = 0; j < NMEAS; j++) begin
            per_a[j] = pa; ph_a[j] = pha; per_b[j] = pb; ph_b[j] = phb;
        end
    endtask

    task automatic set_ro_rand();
        for (int j = 0; j < NMEAS; j++) begin
            per_a[j] = $urandom_range(20, 4);
            per_b[j] = $urandom_range(20, 4);
            ph_a[j]  = $urandom_range(per_a[j] - 1, 0);
            ph_b[j]  = $urandom_range(per_b[j] - 1, 0);
        end
    endtask

    // mode 0: single start pulse; 1: extra start pulse at cycle 10 then watch
    // for a spurious second run; 2: start held high so the next run chains;
    // 3: reset asserted at cycle 30.
    task automatic run(input logic [SEL_W-1:0] ba, input logic [SEL_W-1:0] bb,
                       input int mode, input bit chained);
        logic [RESP_BITS-1:0] exp_resp = '0;
        int exp_ties = 0;
        int last_m;
        int j, k;
        for (int b = 0; b < RESP_BITS; b++) begin
            int votes = 0;
            for (int t = 0; t < TRIALS; t++) begin
                int ca = edges(b * TRIALS + t, 1'b1);
                int cb = edges(b * TRIALS + t, 1'b0);
                if (ca > cb) votes++;
                if (ca == cb && exp_ties < 255) exp_ties++;
            end
            exp_resp[b] = (2 * votes > TRIALS);
        end
        last_m = (mode == 1) ? D + 1 + 2 * L : (mode == 3) ? 31 : D + 1;
        for (int m = chained ? 1 : 0; m <= last_m; m++) begin
            ro_a      = ro_val(m, 1'b1);
            ro_b      = ro_val(m, 1'b0);
            challenge = {bb, ba};
            start     = (m == 0) || (mode == 1 && m == 10) || (mode == 2);
            if (mode == 3 && m == 30) begin
                rst_n = 1'b1;
            end else if (mode == 3 && m == 31) begin
                check_val("rst_busy", busy, 0);
                check_val("rst_ro_ena", ro_ena, 0);
                check_val("rst_done", done, 0);
                check_val("rst_response", response, 0);
                check_val("rst_tie_cnt", tie_cnt, 0);
                rst_n = 1'b0;
                start = 1'b0;
            end else begin
                check_val("busy", busy, (m >= 1 && m <= D));
                check_val("done", done, (m == D));
                check_val("ro_ena", ro_ena, (m >= 1 && m <= D - 1 && ((m - 1) % L) < L - 1));
                if (m >= 1) begin
                    j = (m - 1) / L;
                    if (j > NMEAS - 1) j = NMEAS - 1;
                    k = j / TRIALS;
                    check_val("sel_a", sel_a, (int'(ba) + k) % (1 << SEL_W));
                    check_val("sel_b", sel_b, (int'(bb) + k) % (1 << SEL_W));
                end
                if (m == D || m == D + 1) begin
                    check_val("response", response, exp_resp);
                    check_val("tie_cnt", tie_cnt, exp_ties);
                end
            end
            @(negedge clk);
        end
        if (mode != 2) start = 1'b0;
    endtask

    initial begin
        // Reset state while reset is asserted.
        repeat (3) @(negedge clk);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_ro_ena", ro_ena, 0);
        check_val("reset_sel_a", sel_a, 0);
        check_val("reset_sel_b", sel_b, 0);
        check_val("reset_response", response, 0);
        check_val("reset_tie_cnt", tie_cnt, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Faster A than B: every bit 1.
        set_ro(8, 0, 12, 0);
        run(5'd0, 5'd16, 0, 1'b0);
        check_val("basic_resp_literal", response, 4'b1111);
        check_val("basic_tie_literal", tie_cnt, 0);

        // Identical oscillators: every comparison ties.
        set_ro(8, 0, 8, 0);
        run(5'd3, 5'd9, 0, 1'b0);
        check_val("tie_resp_literal", response, 4'b0000);
        check_val("tie_cnt_literal", tie_cnt, RESP_BITS * TRIALS);

        // Select wrap-around.
        set_ro_rand();
        run(5'd30, 5'd31, 0, 1'b0);

        // Saturation of cnt_a, plus a start pulse during busy that is ignored.
        set_ro(4, 0, 0, 0);
        run(5'd7, 5'd1, 1, 1'b0);
        check_val("sat_resp_literal", response, 4'b1111);

        // Reset in the middle of counting, then a normal run.
        set_ro_rand();
        run(5'd12, 5'd20, 3, 1'b0);
        repeat (2) @(negedge clk);
        set_ro_rand();
        run(5'd12, 5'd20, 0, 1'b0);

        // Start held high: a second run begins right after DONE.
        set_ro_rand();
        run(5'd2, 5'd25, 2, 1'b0);
        start = 1'b0;
        set_ro_rand();
        run(5'd2, 5'd25, 0, 1'b1);

        // Randomized runs.
        for (int i = 0; i < 5; i++) begin
            set_ro_rand();
            run(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
